// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction RAM between CPU fetch and a loader/debug port.
// Optional macro IMEM_WRITE_PROTECT_EN rejects loader writes outside HOLD and flags them on ld_err.
module imem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              ld_err,
  input  logic              ld_hold,
  output logic              hold_ack,
  output logic [ADDR_W:0]   wr_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W:0]   WR_SAT   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [DATA_W-1:0] ld_rdata_q;
  logic              ld_rvalid_q;
  logic              hold_ack_q;
  logic              wr_gnt;
  logic              wr_blocked;

  assign fetch_data = mem_rdata;
  assign mem_wdata  = ld_wdata;
  assign ld_rdata   = ld_rdata_q;
  assign ld_rvalid  = ld_rvalid_q;
  assign hold_ack   = hold_ack_q;
  assign wr_count   = wr_count_q;

  // Port steering: CPU owns the RAM unless the loader is granted; reset forces the idle CPU view.
  always_comb begin
    ld_gnt    = 1'b0;
    cpu_stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          ld_gnt    = ld_req && (!fetch_req || wait_q == WAIT_MAX);
          cpu_stall = ld_gnt && fetch_req;
        end
        HOLD: begin
          ld_gnt    = ld_req;
          cpu_stall = 1'b1;
        end
        DRAIN: cpu_stall = 1'b1;
        default: ;
      endcase
    end
    mem_addr = ld_gnt ? ld_addr : fetch_addr;
    wr_gnt   = ld_gnt && ld_we;
`ifdef IMEM_WRITE_PROTECT_EN
    wr_blocked = wr_gnt && (state_q == RUN);
`else
    wr_blocked = 1'b0;
`endif
    mem_we = wr_gnt && !wr_blocked;
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    wr_count_d = wr_count_q;
    unique case (state_q)
      RUN: begin
        if (ld_hold) state_d = HOLD;
        if (ld_req && !ld_gnt)
          wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      end
      HOLD:    if (!ld_hold) state_d = DRAIN;
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
    // Entering HOLD restarts the count, even if a write lands in the same cycle.
    if (state_q == RUN && state_d == HOLD)
      wr_count_d = '0;
    else if (mem_we && wr_count_q != WR_SAT)
      wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      wr_count_q  <= '0;
      ld_rdata_q  <= '0;
      ld_rvalid_q <= 1'b0;
      hold_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      wr_count_q  <= wr_count_d;
      hold_ack_q  <= (state_d == HOLD);
      ld_rvalid_q <= ld_gnt && !ld_we;
      if (ld_gnt && !ld_we) ld_rdata_q <= mem_rdata;
    end
  end

`ifdef IMEM_WRITE_PROTECT_EN
  logic ld_err_q;
  always_ff @(posedge clk) begin
    if (reset) ld_err_q <= 1'b0;
    else       ld_err_q <= wr_blocked;
  end
  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 512x32 RAM attached.
// Expectations adapt to IMEM_WRITE_PROTECT_EN when the bench is built with it.
module tb_imem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
`ifdef IMEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_stall;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;
  logic              ld_err;
  logic              ld_hold;
  logic              hold_ack;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              tbClear;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_err(ld_err),
    .ld_hold(ld_hold), .hold_ack(hold_ack), .wr_count(wr_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction RAM model: asynchronous read, synchronous write, bulk clear at start.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (tbClear) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa, input logic lr,
                               input logic lwe, input logic [ADDR_W-1:0] la,
                               input logic [DATA_W-1:0] lwd, input logic lh);
    fetch_req  = fr;
    fetch_addr = fa;
    ld_req     = lr;
    ld_we      = lwe;
    ld_addr    = la;
    ld_wdata   = lwd;
    ld_hold    = lh;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each cycle: drive inputs just after the edge, check 1 ns later, then advance.
  initial begin
    logic [ADDR_W-1:0] ra;
    reset   = 1'b1;
    tbClear = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] reset with random inputs");
    for (int c = 0; c < 3; c++) begin
      ra = ADDR_W'($urandom_range(0, 511));
      applyStimulus(1'($urandom), ra, 1'($urandom), 1'($urandom), ADDR_W'($urandom),
                    $urandom, 1'($urandom));
      checkOutput("rst_gnt", 64'(ld_gnt), 64'(0));
      checkOutput("rst_we", 64'(mem_we), 64'(0));
      checkOutput("rst_stall", 64'(cpu_stall), 64'(0));
      checkOutput("rst_addr", 64'(mem_addr), 64'(ra));
      tick();
    end
    reset   = 1'b0;
    tbClear = 1'b0;
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    checkOutput("rst_hold_ack", 64'(hold_ack), 64'(0));
    checkOutput("rst_rvalid", 64'(ld_rvalid), 64'(0));
    checkOutput("rst_wr_count", 64'(wr_count), 64'(0));
    checkOutput("rst_ld_err", 64'(ld_err), 64'(0));
    checkOutput("rst_run_stall", 64'(cpu_stall), 64'(0));
    tick();

    $display("[TB] idle CPU write and readback");
    applyStimulus(0, 0, 1, 1, 5, 32'hDEADBEEF, 0);
    checkOutput("wr_gnt", 64'(ld_gnt), 64'(1));
    checkOutput("wr_mem_we", 64'(mem_we), WP ? 64'(0) : 64'(1));
    checkOutput("wr_mem_addr", 64'(mem_addr), 64'(5));
    checkOutput("wr_stall", 64'(cpu_stall), 64'(0));
    tick();
    applyStimulus(0, 0, 1, 0, 5, 0, 0);
    checkOutput("rd_gnt", 64'(ld_gnt), 64'(1));
    checkOutput("rd_mem_we", 64'(mem_we), 64'(0));
    checkOutput("wr_ld_err", 64'(ld_err), WP ? 64'(1) : 64'(0));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd_rvalid", 64'(ld_rvalid), 64'(1));
    checkOutput("rd_rdata", 64'(ld_rdata), WP ? 64'(0) : 64'(32'hDEADBEEF));
    checkOutput("rd_ld_err_clr", 64'(ld_err), 64'(0));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd_rvalid_pulse", 64'(ld_rvalid), 64'(0));
    checkOutput("rd_rdata_hold", 64'(ld_rdata), WP ? 64'(0) : 64'(32'hDEADBEEF));
    tick();

    $display("[TB] starvation counter");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 9'h040, 1, 0, 5, 0, 0);
      if (c < 4) begin
        checkOutput($sformatf("starve_gnt_c%0d", c), 64'(ld_gnt), 64'(0));
        checkOutput($sformatf("starve_stall_c%0d", c), 64'(cpu_stall), 64'(0));
        checkOutput($sformatf("starve_addr_c%0d", c), 64'(mem_addr), 64'(9'h040));
      end else if (c == 4) begin
        checkOutput("starve_gnt_c4", 64'(ld_gnt), 64'(1));
        checkOutput("starve_stall_c4", 64'(cpu_stall), 64'(1));
        checkOutput("starve_addr_c4", 64'(mem_addr), 64'(5));
      end else begin
        checkOutput("starve_gnt_c5", 64'(ld_gnt), 64'(0));
        checkOutput("starve_stall_c5", 64'(cpu_stall), 64'(0));
        checkOutput("starve_rvalid_c5", 64'(ld_rvalid), 64'(1));
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] loader write in RUN");
    applyStimulus(0, 0, 1, 1, 20, 32'h12345678, 0);
    checkOutput("runwr_gnt", 64'(ld_gnt), 64'(1));
    checkOutput("runwr_mem_we", 64'(mem_we), WP ? 64'(0) : 64'(1));
    tick();
    applyStimulus(0, 20, 0, 0, 0, 0, 0);
    checkOutput("runwr_ld_err", 64'(ld_err), WP ? 64'(1) : 64'(0));
    checkOutput("runwr_mem", 64'(fetch_data), WP ? 64'(0) : 64'(32'h12345678));
    tick();
    applyStimulus(0, 20, 0, 0, 0, 0, 0);
    checkOutput("runwr_ld_err_pulse", 64'(ld_err), 64'(0));
    tick();

    $display("[TB] hold-mode program load");
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("hold_enter_ack", 64'(hold_ack), 64'(0));
    checkOutput("hold_enter_stall", 64'(cpu_stall), 64'(0));
    tick();
    applyStimulus(1, 0, 1, 1, 0, 32'h3c011001, 1);
    checkOutput("hold_ack", 64'(hold_ack), 64'(1));
    checkOutput("hold_stall", 64'(cpu_stall), 64'(1));
    checkOutput("hold_wr0_gnt", 64'(ld_gnt), 64'(1));
    checkOutput("hold_wr0_we", 64'(mem_we), 64'(1));
    checkOutput("hold_wr_count0", 64'(wr_count), 64'(0));
    tick();
    applyStimulus(1, 0, 1, 1, 1, 32'h343a0000, 1);
    checkOutput("hold_wr1_we", 64'(mem_we), 64'(1));
    checkOutput("hold_wr_count1", 64'(wr_count), 64'(1));
    tick();
    applyStimulus(1, 0, 1, 1, 2, 32'h8f510000, 1);
    checkOutput("hold_wr2_we", 64'(mem_we), 64'(1));
    checkOutput("hold_wr_count2", 64'(wr_count), 64'(2));
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_wr_count3", 64'(wr_count), 64'(3));
    checkOutput("hold_exit_stall", 64'(cpu_stall), 64'(1));
    tick();
    applyStimulus(1, 0, 1, 1, 0, 32'hFFFFFFFF, 0);
    checkOutput("drain_stall", 64'(cpu_stall), 64'(1));
    checkOutput("drain_ack", 64'(hold_ack), 64'(0));
    checkOutput("drain_gnt", 64'(ld_gnt), 64'(0));
    checkOutput("drain_we", 64'(mem_we), 64'(0));
    checkOutput("drain_addr", 64'(mem_addr), 64'(0));
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("post_drain_stall", 64'(cpu_stall), 64'(0));
    checkOutput("post_drain_fetch0", 64'(fetch_data), 64'(32'h3c011001));
    checkOutput("post_drain_wr_count", 64'(wr_count), 64'(3));
    tick();
    applyStimulus(1, 2, 0, 0, 0, 0, 0);
    checkOutput("post_drain_fetch2", 64'(fetch_data), 64'(32'h8f510000));
    tick();

    $display("[TB] reset during HOLD");
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 1, 1, 10, 32'hAAAA0001, 1);
    tick();
    applyStimulus(1, 0, 1, 1, 11, 32'hAAAA0002, 1);
    tick();
    reset = 1'b1;
    applyStimulus(1, 12, 1, 1, 12, 32'hBBBB0003, 1);
    checkOutput("midrst_wr_count_before", 64'(wr_count), 64'(2));
    checkOutput("midrst_gnt", 64'(ld_gnt), 64'(0));
    checkOutput("midrst_we", 64'(mem_we), 64'(0));
    checkOutput("midrst_stall", 64'(cpu_stall), 64'(0));
    tick();
    reset = 1'b0;
    applyStimulus(1, 12, 1, 0, 10, 0, 0);
    checkOutput("midrst_hold_ack", 64'(hold_ack), 64'(0));
    checkOutput("midrst_wr_count", 64'(wr_count), 64'(0));
    checkOutput("midrst_run_gnt", 64'(ld_gnt), 64'(0));
    checkOutput("midrst_run_stall", 64'(cpu_stall), 64'(0));
    checkOutput("midrst_dropped_wr", 64'(fetch_data), 64'(0));
    tick();
    applyStimulus(1, 11, 0, 0, 0, 0, 0);
    checkOutput("midrst_fetch11", 64'(fetch_data), 64'(32'hAAAA0002));
    tick();

    $display("[TB] loader write in HOLD");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 1, 1, 20, 32'h55AA55AA, 1);
    checkOutput("holdwr_gnt", 64'(ld_gnt), 64'(1));
    checkOutput("holdwr_we", 64'(mem_we), 64'(1));
    tick();
    applyStimulus(0, 20, 0, 0, 0, 0, 0);
    checkOutput("holdwr_ld_err", 64'(ld_err), 64'(0));
    checkOutput("holdwr_wr_count", 64'(wr_count), 64'(1));
    tick();
    applyStimulus(0, 20, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 20, 0, 0, 0, 0, 0);
    checkOutput("holdwr_stall", 64'(cpu_stall), 64'(0));
    checkOutput("holdwr_mem", 64'(fetch_data), 64'(32'h55AA55AA));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port 512x32 instruction memory between the CPU fetch path and a program loader/debug port.
- CPU fetch has priority. A starvation counter forces loader grants, and a hold mode locks the CPU out for bulk program load.
- Sits between the fetch stage, the loader and the instruction RAM. The RAM has asynchronous read and synchronous write.

Parameters:
- ADDR_W, 9, word-address width of the instruction memory
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, maximum consecutive cycles a pending loader request may be refused in RUN (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- fetch_req  in  1  CPU wants to fetch this cycle
- fetch_addr  in  ADDR_W  CPU fetch word address
- fetch_data  out  DATA_W  instruction to CPU (= mem_rdata)
- cpu_stall  out  1  CPU must hold PC and discard fetch_data this cycle
- ld_req  in  1  loader access request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader access performed this cycle
- ld_rdata  out  DATA_W  registered loader read data
- ld_rvalid  out  1  ld_rdata valid (one-cycle pulse)
- ld_err  out  1  write rejected (see Optional Feature)
- ld_hold  in  1  request exclusive loader ownership
- hold_ack  out  1  arbiter in HOLD
- wr_count  out  ADDR_W+1  words written since last HOLD entry
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM asynchronous read data

Behaviour:
- State register has three states: RUN, HOLD, DRAIN. Reset returns it to RUN.
- Reset values: ld_rdata=0, ld_rvalid=0, ld_err=0, hold_ack=0, wr_count=0, wait_cnt=0.
- While reset is high: ld_gnt=0, mem_we=0, cpu_stall=0, mem_addr=fetch_addr.
- ld_gnt, cpu_stall, mem_addr, mem_we and mem_wdata are combinational from state, inputs and wait_cnt.
- RUN:
  - Loader is granted iff ld_req && (!fetch_req || wait_cnt==MAX_WAIT).
  - On grant: mem_addr=ld_addr, mem_we=ld_we, mem_wdata=ld_wdata. cpu_stall = fetch_req.
  - Otherwise: mem_addr=fetch_addr, mem_we=0, cpu_stall=0.
- wait_cnt:
  - Increments when ld_req && !ld_gnt, saturating at MAX_WAIT.
  - Clears on any grant or when ld_req=0.
  - Never counts in HOLD or DRAIN.
- RUN->HOLD when ld_hold=1 at the clock edge. Arbitration in the transition cycle follows RUN rules. wr_count clears on this transition.
- HOLD:
  - hold_ack=1 and cpu_stall=1 every cycle.
  - ld_gnt=ld_req; one access per cycle, no starvation logic.
  - HOLD->DRAIN when ld_hold=0.
- DRAIN lasts exactly one cycle:
  - cpu_stall=1, ld_gnt=0, mem_we=0, mem_addr=fetch_addr, hold_ack=0.
  - Next state is RUN regardless of ld_hold.
  - Re-entry to HOLD requires passing through RUN.
- Loader reads: a granted read (ld_we=0) registers mem_rdata into ld_rdata, with ld_rvalid=1 on the following cycle only. ld_rdata holds its value otherwise.
- wr_count:
  - Increments on every cycle with mem_we=1.
  - Saturates at 2^ADDR_W (512 at default).
- A write and a fetch to the same address never coincide, because the CPU is stalled during any loader grant.
- Reset asserted mid-HOLD or mid-DRAIN: next cycle is RUN with hold_ack=0, wr_count=0, wait_cnt=0. A grant in progress is dropped.

Optional Feature:
- Macro: IMEM_WRITE_PROTECT_EN.
- Defined:
  - A granted loader write in RUN still asserts ld_gnt and stalls the CPU as usual.
  - mem_we is forced 0 and wr_count does not increment.
  - ld_err=1 for exactly the next cycle.
  - Writes in HOLD are unaffected.
- Undefined: writes are honoured in any state and ld_err is tied 0.

Test Plan:
1. Reset: hold reset 3 cycles with random inputs -> ld_gnt=0, mem_we=0, cpu_stall=0, hold_ack=0, ld_rvalid=0, wr_count=0; state RUN after release.
2. Idle CPU write/readback: fetch_req=0; write addr 5 data 0xDEADBEEF -> ld_gnt=1, mem_we=1 same cycle. Read addr 5 -> ld_rvalid=1 next cycle with ld_rdata=0xDEADBEEF (macro undefined).
3. Starvation: fetch_req=1 constant; read request held from cycle 0 -> ld_gnt=0 on cycles 0-3; ld_gnt=1 and cpu_stall=1 on cycle 4 only; wait_cnt=0 on cycle 5.
4. Hold load: ld_hold=1 -> hold_ack=1 next cycle, cpu_stall=1. Write 0x3c011001, 0x343a0000, 0x8f510000 to addrs 0-2 -> wr_count=3. Drop ld_hold -> one DRAIN cycle (cpu_stall=1, hold_ack=0, ld_gnt=0), then cpu_stall=0 and fetch_data of addr 0 = 0x3c011001.
5. Reset mid-HOLD after 2 writes -> next cycle hold_ack=0, wr_count=0, cpu_stall follows RUN rules.
6. IMEM_WRITE_PROTECT_EN defined: write in RUN with fetch_req=0 -> ld_gnt=1, mem_we=0, ld_err=1 next cycle, memory unchanged. Same write inside HOLD -> mem_we=1, ld_err=0.
